// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: default field widths, the "no exception" code
// and the Tnew hazard-counter encoding used by every pipeline stage register.
package cpu_pkg;

   localparam int XLEN_DEF   = 32;
   localparam int RAW_DEF    = 5;
   localparam int TNEW_W_DEF = 2;
   localparam int EXC_W_DEF  = 5;
   localparam int CNT_W_DEF  = 16;

   localparam int EXC_NONE   = 0;

   // Tnew = number of cycles before the producing instruction's result can be forwarded.
   typedef enum logic [1:0] {
      TNEW_READY = 2'd0,
      TNEW_1     = 2'd1,
      TNEW_2     = 2'd2,
      TNEW_3     = 2'd3
   } tnew_e;

endpackage

// File: rtl/tnew_dec.sv
// Saturating decrement of the Tnew hazard counter: ready (0) stays ready.
module tnew_dec
   import cpu_pkg::*;
#(
   parameter int W = TNEW_W_DEF
) (
   input  logic [W-1:0] i_tnew,
   output logic [W-1:0] o_tnew
);

   assign o_tnew = (i_tnew == W'(TNEW_READY)) ? W'(TNEW_READY) : (i_tnew - W'(1));

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register (D/E, E/M, M/W differ only in parameters).
// Each edge does exactly one of: flush (bubble), stall (hold), load.
module pipe_stage_reg
   import cpu_pkg::*;
#(
   parameter int XLEN             = XLEN_DEF,
   parameter int RAW              = RAW_DEF,
   parameter int TNEW_W           = TNEW_W_DEF,
   parameter int DEC_TNEW         = 1,
   parameter int EXC_W            = EXC_W_DEF,
   parameter int KEEP_PC_ON_FLUSH = 1,
   parameter int CNT_W            = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              flush,
   input  logic              valid_i,
   input  logic [XLEN-1:0]   instr_i,
   input  logic [XLEN-1:0]   pc8_i,
   input  logic [XLEN-1:0]   ao_i,
   input  logic [XLEN-1:0]   v2_i,
   input  logic [RAW-1:0]    a2_i,
   input  logic [RAW-1:0]    a3_i,
   input  logic              we_i,
   input  logic [TNEW_W-1:0] tnew_i,
   input  logic [EXC_W-1:0]  exc_i,
   input  logic              bd_i,
   output logic              valid_o,
   output logic [XLEN-1:0]   instr_o,
   output logic [XLEN-1:0]   pc8_o,
   output logic [XLEN-1:0]   ao_o,
   output logic [XLEN-1:0]   v2_o,
   output logic [RAW-1:0]    a2_o,
   output logic [RAW-1:0]    a3_o,
   output logic              we_o,
   output logic [TNEW_W-1:0] tnew_o,
   output logic [EXC_W-1:0]  exc_o,
   output logic              bd_o,
   output logic [CNT_W-1:0]  stall_cnt
);

   localparam logic [EXC_W-1:0] W_EXC_NONE = EXC_W'(EXC_NONE);

   logic              r_valid;
   logic [XLEN-1:0]   r_instr;
   logic [XLEN-1:0]   r_pc8;
   logic [XLEN-1:0]   r_ao;
   logic [XLEN-1:0]   r_v2;
   logic [RAW-1:0]    r_a2;
   logic [RAW-1:0]    r_a3;
   logic              r_we;
   logic [TNEW_W-1:0] r_tnew;
   logic [EXC_W-1:0]  r_exc;
   logic              r_bd;
   logic [CNT_W-1:0]  r_stall_cnt;

   logic [TNEW_W-1:0] w_tnew_dec;
   logic [TNEW_W-1:0] w_tnew_next;
   logic              w_we_next;
   logic              w_cnt_en;
   logic [XLEN-1:0]   w_pc8_bubble;
   logic              w_bd_bubble;

   tnew_dec #(.W(TNEW_W)) u_tnew_dec (
      .i_tnew (tnew_i),
      .o_tnew (w_tnew_dec)
   );

   assign w_tnew_next = (DEC_TNEW != 0) ? w_tnew_dec : tnew_i;

   // Writes to $0, from bubbles, or from excepting instructions must never retire.
   assign w_we_next = we_i & valid_i & (a3_i != '0) & (exc_i == W_EXC_NONE);

   assign w_pc8_bubble = (KEEP_PC_ON_FLUSH != 0) ? pc8_i : '0;
   assign w_bd_bubble  = (KEEP_PC_ON_FLUSH != 0) ? bd_i  : 1'b0;

   // Only stalls that actually hold a live instruction are counted; flush wins over stall.
   assign w_cnt_en = stall & ~flush & r_valid;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_valid <= 1'b0;
         r_instr <= '0;
         r_pc8   <= '0;
         r_ao    <= '0;
         r_v2    <= '0;
         r_a2    <= '0;
         r_a3    <= '0;
         r_we    <= 1'b0;
         r_tnew  <= '0;
         r_exc   <= '0;
         r_bd    <= 1'b0;
      end else if (flush) begin
         r_valid <= 1'b0;
         r_instr <= '0;
         r_pc8   <= w_pc8_bubble;
         r_ao    <= '0;
         r_v2    <= '0;
         r_a2    <= '0;
         r_a3    <= '0;
         r_we    <= 1'b0;
         r_tnew  <= '0;
         r_exc   <= '0;
         r_bd    <= w_bd_bubble;
      end else if (!stall) begin
         r_valid <= valid_i;
         r_instr <= instr_i;
         r_pc8   <= pc8_i;
         r_ao    <= ao_i;
         r_v2    <= v2_i;
         r_a2    <= a2_i;
         r_a3    <= a3_i;
         r_we    <= w_we_next;
         r_tnew  <= w_tnew_next;
         r_exc   <= exc_i;
         r_bd    <= bd_i;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_stall_cnt <= '0;
      end else if (w_cnt_en && (r_stall_cnt != '1)) begin
         r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
   end

   assign valid_o   = r_valid;
   assign instr_o   = r_instr;
   assign pc8_o     = r_pc8;
   assign ao_o      = r_ao;
   assign v2_o      = r_v2;
   assign a2_o      = r_a2;
   assign a3_o      = r_a3;
   assign we_o      = r_we;
   assign tnew_o    = r_tnew;
   assign exc_o     = r_exc;
   assign bd_o      = r_bd;
   assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: a default-configured stage (4-bit stall counter)
// and a second stage with Tnew pass-through and zeroed bubble PC share the same inputs.
module tb_pipe_stage_reg;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        flush;
   logic        valid_i;
   logic [31:0] instr_i;
   logic [31:0] pc8_i;
   logic [31:0] ao_i;
   logic [31:0] v2_i;
   logic [4:0]  a2_i;
   logic [4:0]  a3_i;
   logic        we_i;
   logic [1:0]  tnew_i;
   logic [4:0]  exc_i;
   logic        bd_i;

   logic        valid_o;
   logic [31:0] instr_o;
   logic [31:0] pc8_o;
   logic [31:0] ao_o;
   logic [31:0] v2_o;
   logic [4:0]  a2_o;
   logic [4:0]  a3_o;
   logic        we_o;
   logic [1:0]  tnew_o;
   logic [4:0]  exc_o;
   logic        bd_o;
   logic [3:0]  stall_cnt;

   logic        p_valid_o;
   logic [31:0] p_instr_o;
   logic [31:0] p_pc8_o;
   logic [31:0] p_ao_o;
   logic [31:0] p_v2_o;
   logic [4:0]  p_a2_o;
   logic [4:0]  p_a3_o;
   logic        p_we_o;
   logic [1:0]  p_tnew_o;
   logic [4:0]  p_exc_o;
   logic        p_bd_o;
   logic [15:0] p_stall_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   pipe_stage_reg #(.CNT_W(4)) u_dut (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush),
      .valid_i(valid_i), .instr_i(instr_i), .pc8_i(pc8_i), .ao_i(ao_i), .v2_i(v2_i),
      .a2_i(a2_i), .a3_i(a3_i), .we_i(we_i), .tnew_i(tnew_i), .exc_i(exc_i), .bd_i(bd_i),
      .valid_o(valid_o), .instr_o(instr_o), .pc8_o(pc8_o), .ao_o(ao_o), .v2_o(v2_o),
      .a2_o(a2_o), .a3_o(a3_o), .we_o(we_o), .tnew_o(tnew_o), .exc_o(exc_o), .bd_o(bd_o),
      .stall_cnt(stall_cnt)
   );

   pipe_stage_reg #(.DEC_TNEW(0), .KEEP_PC_ON_FLUSH(0)) u_dut_pass (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush),
      .valid_i(valid_i), .instr_i(instr_i), .pc8_i(pc8_i), .ao_i(ao_i), .v2_i(v2_i),
      .a2_i(a2_i), .a3_i(a3_i), .we_i(we_i), .tnew_i(tnew_i), .exc_i(exc_i), .bd_i(bd_i),
      .valid_o(p_valid_o), .instr_o(p_instr_o), .pc8_o(p_pc8_o), .ao_o(p_ao_o), .v2_o(p_v2_o),
      .a2_o(p_a2_o), .a3_o(p_a3_o), .we_o(p_we_o), .tnew_o(p_tnew_o), .exc_o(p_exc_o),
      .bd_o(p_bd_o), .stall_cnt(p_stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      n_fail = n_fail + 1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests = n_tests + 1;
      if (obs !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle 1 time unit past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc8,
                        input logic [31:0] ao, input logic [31:0] v2, input logic [4:0] a2,
                        input logic [4:0] a3, input logic we, input logic [1:0] tnew,
                        input logic [4:0] exc, input logic bd);
      valid_i = v;   instr_i = instr; pc8_i = pc8; ao_i = ao; v2_i = v2;
      a2_i    = a2;  a3_i    = a3;    we_i  = we;  tnew_i = tnew;
      exc_i   = exc; bd_i    = bd;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".valid"}, {31'd0, valid_o}, 32'd0);
      check({tag, ".instr"}, instr_o, 32'd0);
      check({tag, ".pc8"},   pc8_o,   32'd0);
      check({tag, ".ao"},    ao_o,    32'd0);
      check({tag, ".v2"},    v2_o,    32'd0);
      check({tag, ".a3"},    {27'd0, a3_o}, 32'd0);
      check({tag, ".we"},    {31'd0, we_o}, 32'd0);
      check({tag, ".tnew"},  {30'd0, tnew_o}, 32'd0);
      check({tag, ".bd"},    {31'd0, bd_o}, 32'd0);
      check({tag, ".cnt"},   {28'd0, stall_cnt}, 32'd0);
   endtask

   initial begin
      reset = 1'b0;
      stall = 1'b0;
      flush = 1'b0;
      drive(1'b1, 32'hDEADBEEF, 32'h1111, 32'h2222, 32'h3333, 5'd9, 5'd9, 1'b1, 2'd3, 5'd0, 1'b1);
      #3;
      check_all_zero("reset");
      @(negedge clk);
      reset = 1'b1;

      // Basic load of a lw-like instruction.
      drive(1'b1, 32'h8C220004, 32'h00003008, 32'h12345678, 32'hCAFEBABE, 5'd2, 5'd2,
            1'b1, 2'd2, 5'd0, 1'b0);
      tick();
      check("ld.valid", {31'd0, valid_o}, 32'd1);
      check("ld.instr", instr_o, 32'h8C220004);
      check("ld.pc8",   pc8_o,   32'h00003008);
      check("ld.ao",    ao_o,    32'h12345678);
      check("ld.v2",    v2_o,    32'hCAFEBABE);
      check("ld.a2",    {27'd0, a2_o}, 32'd2);
      check("ld.a3",    {27'd0, a3_o}, 32'd2);
      check("ld.we",    {31'd0, we_o}, 32'd1);
      check("ld.tnew",  {30'd0, tnew_o}, 32'd1);
      check("ld.exc",   {27'd0, exc_o}, 32'd0);
      check("ld.bd",    {31'd0, bd_o}, 32'd0);
      check("ld.pass_tnew", {30'd0, p_tnew_o}, 32'd2);

      // Tnew saturation at 0 and write to $0 suppression.
      drive(1'b1, 32'h00000000, 32'h300C, 32'h0, 32'h0, 5'd0, 5'd0, 1'b1, 2'd0, 5'd0, 1'b1);
      tick();
      check("sat.tnew", {30'd0, tnew_o}, 32'd0);
      check("zero.we",  {31'd0, we_o}, 32'd0);
      check("zero.bd",  {31'd0, bd_o}, 32'd1);

      // Bubble from upstream: valid=0 gates we; a stall over an invalid stage is not counted.
      drive(1'b0, 32'h11111111, 32'h3010, 32'h5, 32'h6, 5'd4, 5'd5, 1'b1, 2'd3, 5'd0, 1'b0);
      tick();
      check("inv.we",   {31'd0, we_o}, 32'd0);
      check("inv.tnew", {30'd0, tnew_o}, 32'd2);
      check("inv.pass_tnew", {30'd0, p_tnew_o}, 32'd3);
      stall = 1'b1;
      tick();
      check("inv.cnt",  {28'd0, stall_cnt}, 32'd0);
      stall = 1'b0;

      // Load a known instruction, then stall 3 cycles while the inputs churn.
      drive(1'b1, 32'hAAAA5555, 32'h3014, 32'h77, 32'h88, 5'd6, 5'd7, 1'b1, 2'd1, 5'd0, 1'b1);
      tick();
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 32'h0F0F0F00 + i, 32'h4000 + i, 32'h99, 32'h98, 5'd1, 5'd0, 1'b0,
               2'd3, 5'd2, 1'b0);
         tick();
      end
      check("stl.valid", {31'd0, valid_o}, 32'd1);
      check("stl.instr", instr_o, 32'hAAAA5555);
      check("stl.pc8",   pc8_o,   32'h3014);
      check("stl.a3",    {27'd0, a3_o}, 32'd7);
      check("stl.we",    {31'd0, we_o}, 32'd1);
      check("stl.tnew",  {30'd0, tnew_o}, 32'd0);
      check("stl.exc",   {27'd0, exc_o}, 32'd0);
      check("stl.bd",    {31'd0, bd_o}, 32'd1);
      check("stl.cnt",   {28'd0, stall_cnt}, 32'd3);

      // Flush and stall together: flush wins, counter untouched.
      flush = 1'b1;
      drive(1'b1, 32'h12340000, 32'h00003008, 32'h1, 32'h2, 5'd3, 5'd3, 1'b1, 2'd2, 5'd0, 1'b1);
      tick();
      check("fl.valid", {31'd0, valid_o}, 32'd0);
      check("fl.we",    {31'd0, we_o}, 32'd0);
      check("fl.instr", instr_o, 32'd0);
      check("fl.pc8",   pc8_o,   32'h00003008);
      check("fl.bd",    {31'd0, bd_o}, 32'd1);
      check("fl.tnew",  {30'd0, tnew_o}, 32'd0);
      check("fl.a3",    {27'd0, a3_o}, 32'd0);
      check("fl.cnt",   {28'd0, stall_cnt}, 32'd3);
      check("fl.pass_pc8", p_pc8_o, 32'd0);
      check("fl.pass_bd",  {31'd0, p_bd_o}, 32'd0);
      flush = 1'b0;
      stall = 1'b0;

      // Excepting instruction never writes back.
      drive(1'b1, 32'h0000000C, 32'h3020, 32'h0, 32'h0, 5'd3, 5'd3, 1'b1, 2'd1, 5'd4, 1'b0);
      tick();
      check("exc.exc", {27'd0, exc_o}, 32'd4);
      check("exc.we",  {31'd0, we_o}, 32'd0);
      check("exc.valid", {31'd0, valid_o}, 32'd1);

      // Long stall: 3 + 20 saturates the 4-bit counter at 15.
      stall = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
      end
      check("sat.cnt",  {28'd0, stall_cnt}, 32'd15);
      check("sat.pass_cnt", {16'd0, p_stall_cnt}, 32'd23);

      // Reset asserted between edges mid-stall clears everything at once.
      #2;
      reset = 1'b0;
      #1;
      check_all_zero("arst");
      @(negedge clk);
      reset = 1'b1;
      tick();
      check("post.valid", {31'd0, valid_o}, 32'd0);
      check("post.instr", instr_o, 32'd0);
      check("post.cnt",   {28'd0, stall_cnt}, 32'd0);
      stall = 1'b0;

      // First load after reset behaves normally.
      drive(1'b1, 32'h01234567, 32'h3100, 32'hA, 32'hB, 5'd8, 5'd31, 1'b1, 2'd3, 5'd0, 1'b0);
      tick();
      check("rl.tnew",  {30'd0, tnew_o}, 32'd2);
      check("rl.we",    {31'd0, we_o}, 32'd1);
      check("rl.a3",    {27'd0, a3_o}, 32'd31);
      check("rl.instr", instr_o, 32'h01234567);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
